// File: rtl/ice_cmd_framer.sv
// Receive-side ICE command framer: parses type/event/len/payload frames from the UART byte stream.
// Optional inter-byte timeout with NAK reporting is compiled in when ICE_FRAMER_TIMEOUT_EN is defined.
module ice_cmd_framer #(
   parameter int PAYLOAD_DEPTH  = 256,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_latch,
   input  logic [7:0] rx_data,
   output logic       frame_valid,
   output logic [7:0] frame_type,
   output logic [7:0] frame_event,
   output logic [7:0] frame_len,
   output logic [7:0] pl_data,
   output logic       pl_empty,
   input  logic       pl_rd,
   input  logic       frame_ack,
   output logic       nak_req,
   output logic [7:0] nak_event,
   output logic [7:0] nak_code,
   output logic [7:0] drop_cnt
);

   localparam int PW = $clog2(PAYLOAD_DEPTH);

   if (PAYLOAD_DEPTH < 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("ice_cmd_framer: PAYLOAD_DEPTH must be >= 255 and TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic [2:0] {IDLE, EVENT, LEN, PAYLOAD, READY} state_t;

   state_t          state;
   logic            rx_prev;
   logic            accept;
   logic            timeout_fire;
   logic            in_frame;
   logic            wr_en;
   logic [7:0]      remaining;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [7:0]      mem [PAYLOAD_DEPTH];

   // A held rx_latch level counts as a single byte, so only the rising edge is accepted.
   assign accept   = rx_latch & ~rx_prev;
   assign in_frame = (state == EVENT) || (state == LEN) || (state == PAYLOAD);
   assign wr_en    = (state == PAYLOAD) && accept && !timeout_fire;
   assign pl_empty = (rd_ptr == wr_ptr);
   assign pl_data  = pl_empty ? 8'h00 : mem[rd_ptr];

`ifdef ICE_FRAMER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [TW-1:0] idle_cnt;

   assign timeout_fire = in_frame && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt  <= '0;
         nak_req   <= 1'b0;
         nak_event <= 8'h00;
         nak_code  <= 8'h00;
      end else begin
         nak_req <= timeout_fire;
         if (timeout_fire || !in_frame || accept) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + TW'(1);
         end
         // An abort before the event byte arrived has no event ID to report.
         if (timeout_fire) begin
            nak_event <= (state == EVENT) ? 8'h00 : frame_event;
            nak_code  <= 8'h01;
         end
      end
   end
`else
   assign timeout_fire = 1'b0;
   assign nak_req      = 1'b0;
   assign nak_event    = 8'h00;
   assign nak_code     = 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rx_prev     <= 1'b0;
         frame_valid <= 1'b0;
         frame_type  <= 8'h00;
         frame_event <= 8'h00;
         frame_len   <= 8'h00;
         remaining   <= 8'h00;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         drop_cnt    <= 8'h00;
      end else begin
         rx_prev <= rx_latch;
         if (timeout_fire) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     frame_type <= rx_data;
                     state      <= EVENT;
                  end
               end
               EVENT: begin
                  if (accept) begin
                     frame_event <= rx_data;
                     state       <= LEN;
                  end
               end
               LEN: begin
                  if (accept) begin
                     frame_len <= rx_data;
                     remaining <= rx_data;
                     if (rx_data == 8'h00) begin
                        frame_valid <= 1'b1;
                        state       <= READY;
                     end else begin
                        state <= PAYLOAD;
                     end
                  end
               end
               PAYLOAD: begin
                  if (accept) begin
                     wr_ptr    <= wr_ptr + PW'(1);
                     remaining <= remaining - 8'h01;
                     if (remaining == 8'h01) begin
                        frame_valid <= 1'b1;
                        state       <= READY;
                     end
                  end
               end
               READY: begin
                  if (accept && drop_cnt != 8'hFF) begin
                     drop_cnt <= drop_cnt + 8'h01;
                  end
                  // Release takes priority over a read in the same cycle.
                  if (frame_ack) begin
                     frame_valid <= 1'b0;
                     wr_ptr      <= '0;
                     rd_ptr      <= '0;
                     state       <= IDLE;
                  end else if (pl_rd && !pl_empty) begin
                     rd_ptr <= rd_ptr + PW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ice_cmd_framer.sv
// Self-checking bench for ice_cmd_framer: frame-level reference model compared every cycle,
// plus directed vectors with literal expectations. Timeout checks follow ICE_FRAMER_TIMEOUT_EN.
module tb_ice_cmd_framer;

   localparam int T      = 50;
   localparam int PERIOD = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_latch;
   logic [7:0] rx_data;
   logic       frame_valid;
   logic [7:0] frame_type;
   logic [7:0] frame_event;
   logic [7:0] frame_len;
   logic [7:0] pl_data;
   logic       pl_empty;
   logic       pl_rd;
   logic       frame_ack;
   logic       nak_req;
   logic [7:0] nak_event;
   logic [7:0] nak_code;
   logic [7:0] drop_cnt;

   always #(PERIOD / 2) clk = ~clk;

   ice_cmd_framer #(.PAYLOAD_DEPTH(256), .TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_latch    (rx_latch),
      .rx_data     (rx_data),
      .frame_valid (frame_valid),
      .frame_type  (frame_type),
      .frame_event (frame_event),
      .frame_len   (frame_len),
      .pl_data     (pl_data),
      .pl_empty    (pl_empty),
      .pl_rd       (pl_rd),
      .frame_ack   (frame_ack),
      .nak_req     (nak_req),
      .nak_event   (nak_event),
      .nak_code    (nak_code),
      .drop_cnt    (drop_cnt)
   );

   int  n_vec  = 0;
   int  n_miss = 0;
   time last_acc_t;
   time t_nak;
   logic got_nak;

   logic [7:0] f_long [11] = '{8'h62, 8'h0c, 8'h08, 8'hf0, 8'h12, 8'h34, 8'h50, 8'hde, 8'had, 8'hbe, 8'hef};

   task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: collects accepted bytes of the frame in progress and hands over
   // a complete frame once 3 + length bytes have arrived.
   logic       m_prev;
   logic [7:0] part [$];
   logic       m_valid;
   logic [7:0] m_type, m_event, m_len;
   logic [7:0] m_pl [$];
   int         m_rd;
   int         m_drop;
   logic       m_nak_req;
   logic [7:0] m_nak_event, m_nak_code;
   int         cyc = 0;
   int         m_last = 0;
   logic       m_acc, m_fire;

   always @(posedge clk) begin
      cyc++;
      m_nak_req = 1'b0;
      if (reset) begin
         m_prev = 1'b0;
         part.delete();
         m_pl.delete();
         m_valid = 1'b0;
         m_type = 8'h00; m_event = 8'h00; m_len = 8'h00;
         m_rd = 0;
         m_drop = 0;
         m_nak_event = 8'h00;
         m_nak_code  = 8'h00;
      end else begin
         m_acc  = rx_latch && !m_prev;
         m_prev = rx_latch;
         if (m_valid) begin
            if (m_acc && m_drop < 255) m_drop++;
            if (frame_ack) begin
               m_valid = 1'b0;
               m_pl.delete();
               m_rd = 0;
            end else if (pl_rd && m_rd < m_pl.size()) begin
               m_rd++;
            end
         end else begin
            m_fire = 1'b0;
`ifdef ICE_FRAMER_TIMEOUT_EN
            m_fire = (part.size() > 0) && (cyc - m_last == T);
`endif
            if (m_fire) begin
               m_nak_req   = 1'b1;
               m_nak_code  = 8'h01;
               m_nak_event = (part.size() >= 2) ? part[1] : 8'h00;
               part.delete();
            end else if (m_acc) begin
               part.push_back(rx_data);
               m_last = cyc;
               if (part.size() >= 3 && part.size() == 3 + int'(part[2])) begin
                  m_valid = 1'b1;
                  m_type  = part[0];
                  m_event = part[1];
                  m_len   = part[2];
                  m_pl.delete();
                  for (int i = 3; i < part.size(); i++) m_pl.push_back(part[i]);
                  m_rd = 0;
                  part.delete();
               end
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check_output("frame_valid", frame_valid, m_valid);
         check_output("pl_empty", pl_empty,
                      m_valid ? (m_rd == m_pl.size()) : (part.size() <= 3));
         check_output("drop_cnt", drop_cnt, 8'(m_drop));
         check_output("nak_req", nak_req, m_nak_req);
         check_output("nak_event", nak_event, m_nak_event);
         check_output("nak_code", nak_code, m_nak_code);
         if (m_valid) begin
            check_output("frame_type", frame_type, m_type);
            check_output("frame_event", frame_event, m_event);
            check_output("frame_len", frame_len, m_len);
            if (m_rd < m_pl.size()) check_output("pl_data", pl_data, m_pl[m_rd]);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #2;
      rx_latch = 1'b1;
      rx_data  = b;
      @(posedge clk);
      last_acc_t = $time;
      #2;
      rx_latch = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
   endtask

   task automatic pulse(input logic rd, input logic ack);
      @(posedge clk); #2;
      pl_rd     = rd;
      frame_ack = ack;
      @(posedge clk); #2;
      pl_rd     = 1'b0;
      frame_ack = 1'b0;
   endtask

   initial begin
      #(40000 * PERIOD);
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; rx_latch = 1'b0; rx_data = 8'h00; pl_rd = 1'b0; frame_ack = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check_output("rst_valid", frame_valid, 1'b0);
      check_output("rst_empty", pl_empty, 1'b1);
      check_output("rst_type", frame_type, 8'h00);
      check_output("rst_len", frame_len, 8'h00);
      check_output("rst_pl_data", pl_data, 8'h00);
      check_output("rst_drop", drop_cnt, 8'h00);
      check_output("rst_nak", nak_req, 1'b0);

      $display("[TB] zero-length frame");
      apply_stimulus(8'h56, 8'h00, 8'h00);
      @(negedge clk);
      check_output("z_valid", frame_valid, 1'b1);
      check_output("z_type", frame_type, 8'h56);
      check_output("z_event", frame_event, 8'h00);
      check_output("z_len", frame_len, 8'h00);
      check_output("z_empty", pl_empty, 1'b1);
      pulse(1'b0, 1'b1);
      @(negedge clk);
      check_output("z_ack_valid", frame_valid, 1'b0);

      $display("[TB] eight-byte payload frame");
      for (int i = 0; i < 11; i++) send_byte(f_long[i]);
      @(negedge clk);
      check_output("l_len", frame_len, 8'h08);
      check_output("l_event", frame_event, 8'h0c);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_output("l_pl_data", pl_data, f_long[3 + i]);
         pulse(1'b1, 1'b0);
      end
      @(negedge clk);
      check_output("l_empty", pl_empty, 1'b1);
      pulse(1'b1, 1'b0);
      @(negedge clk);
      check_output("l_extra_rd_empty", pl_empty, 1'b1);
      check_output("l_extra_rd_valid", frame_valid, 1'b1);
      pulse(1'b0, 1'b1);

`ifdef ICE_FRAMER_TIMEOUT_EN
      $display("[TB] inter-byte timeout");
      apply_stimulus(8'h76, 8'h01, 8'h02);
      send_byte(8'h00);
      got_nak = 1'b0;
      t_nak   = 0;
      for (int i = 0; i < 200 && !got_nak; i++) begin
         @(negedge clk);
         if (nak_req) begin
            got_nak = 1'b1;
            t_nak   = $time;
         end
      end
      check_output("nak_seen", got_nak, 1'b1);
      if (got_nak) begin
         check_output("nak_delay", 8'((t_nak - last_acc_t - PERIOD / 2) / PERIOD), 8'd50);
         check_output("nak_ev", nak_event, 8'h01);
         check_output("nak_cd", nak_code, 8'h01);
         @(negedge clk);
         check_output("nak_pulse_end", nak_req, 1'b0);
         check_output("nak_ev_hold", nak_event, 8'h01);
      end
`else
      $display("[TB] stalled frame waits without timeout");
      apply_stimulus(8'h76, 8'h01, 8'h02);
      send_byte(8'h00);
      repeat (60) @(posedge clk);
      @(negedge clk);
      check_output("stall_valid", frame_valid, 1'b0);
      check_output("stall_nak", nak_req, 1'b0);
      send_byte(8'h55);
      @(negedge clk);
      check_output("stall_done_valid", frame_valid, 1'b1);
      check_output("stall_len", frame_len, 8'h02);
      check_output("stall_pl0", pl_data, 8'h00);
      pulse(1'b1, 1'b0);
      @(negedge clk);
      check_output("stall_pl1", pl_data, 8'h55);
      pulse(1'b0, 1'b1);
`endif
      apply_stimulus(8'h56, 8'h00, 8'h00);
      @(negedge clk);
      check_output("post_valid", frame_valid, 1'b1);
      check_output("post_type", frame_type, 8'h56);
      pulse(1'b0, 1'b1);

      $display("[TB] drops while a frame is pending");
      apply_stimulus(8'h6f, 8'h04, 8'h02);
      send_byte(8'h70);
      send_byte(8'h01);
      apply_stimulus(8'haa, 8'hbb, 8'hcc);
      @(negedge clk);
      check_output("d_cnt3", drop_cnt, 8'd3);
      check_output("d_type", frame_type, 8'h6f);
      check_output("d_event", frame_event, 8'h04);
      check_output("d_len", frame_len, 8'h02);
      check_output("d_pl", pl_data, 8'h70);
      for (int i = 0; i < 297; i++) send_byte(8'(i));
      @(negedge clk);
      check_output("d_sat", drop_cnt, 8'd255);
      check_output("d_type_hold", frame_type, 8'h6f);
      pulse(1'b1, 1'b1);
      @(negedge clk);
      check_output("rdack_valid", frame_valid, 1'b0);
      check_output("rdack_empty", pl_empty, 1'b1);

      $display("[TB] held rx_latch counts once");
      @(posedge clk); #2;
      rx_latch = 1'b1;
      rx_data  = 8'h3f;
      repeat (5) @(posedge clk);
      #2 rx_latch = 1'b0;
      apply_stimulus(8'h02, 8'h01, 8'h3f);
      @(negedge clk);
      check_output("h_valid", frame_valid, 1'b1);
      check_output("h_type", frame_type, 8'h3f);
      check_output("h_event", frame_event, 8'h02);
      check_output("h_len", frame_len, 8'h01);
      check_output("h_pl", pl_data, 8'h3f);
      pulse(1'b0, 1'b1);

      $display("[TB] reset mid-frame");
      for (int i = 0; i < 7; i++) send_byte(f_long[i]);
      @(posedge clk); #2 reset = 1'b1;
      @(posedge clk); #2 reset = 1'b0;
      @(negedge clk);
      check_output("r_valid", frame_valid, 1'b0);
      check_output("r_empty", pl_empty, 1'b1);
      check_output("r_drop", drop_cnt, 8'h00);
      check_output("r_type", frame_type, 8'h00);
      check_output("r_nak", nak_req, 1'b0);
      for (int i = 0; i < 11; i++) send_byte(f_long[i]);
      @(negedge clk);
      check_output("r2_valid", frame_valid, 1'b1);
      check_output("r2_len", frame_len, 8'h08);
      check_output("r2_pl", pl_data, 8'hf0);
      pulse(1'b0, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
